// File: rtl/microtile_switch_sequencer_if.sv
// rtl/microtile_switch_sequencer_if.sv - select request and tile gating bundle for the microtile switch sequencer
interface microtile_switch_sequencer_if #(
    parameter int NUM_TILES = 4,
    parameter int SEL_W     = 2
);
    logic [SEL_W-1:0]     sel_req;
    logic                 sel_req_valid;
    logic [SEL_W-1:0]     sel_active;
    logic [NUM_TILES-1:0] tile_clk_en;
    logic [NUM_TILES-1:0] tile_rst_n;
    logic                 out_valid;
    logic                 busy;
    logic                 switch_done;
    logic                 sel_err;

    modport master (
        output sel_req, sel_req_valid,
        input  sel_active, tile_clk_en, tile_rst_n, out_valid, busy, switch_done, sel_err
    );

    modport slave (
        input  sel_req, sel_req_valid,
        output sel_active, tile_clk_en, tile_rst_n, out_valid, busy, switch_done, sel_err
    );
endinterface

// File: rtl/microtile_switch_sequencer.sv
// rtl/microtile_switch_sequencer.sv - glitch-free reset-bracketed hand-over of the shared microtile slot
module microtile_switch_sequencer #(
    parameter int NUM_TILES  = 4,
    parameter int SEL_W      = 2,
    parameter int RST_CYCLES = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    microtile_switch_sequencer_if.slave bus
);
    localparam int MAX_CYC = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, GATE, WAKE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [SEL_W-1:0]     pending;
    logic [SEL_W-1:0]     sel_active;
    logic [NUM_TILES-1:0] tile_clk_en;
    logic [NUM_TILES-1:0] tile_rst_n;
    logic                 out_valid;
    logic                 busy;
    logic                 switch_done;
    logic                 sel_err;

    logic                 in_range;
    logic                 req_ok;
    logic [SEL_W-1:0]     pend_nxt;

    function automatic logic [NUM_TILES-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_TILES'(1) << idx;
    endfunction

    // A strobe on the same edge a counter expires must steer that transition,
    // so transitions use the post-latch pending value.
    assign in_range = 32'(bus.sel_req) < NUM_TILES;
    assign req_ok   = bus.sel_req_valid && in_range;
    assign pend_nxt = req_ok ? bus.sel_req : pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAKE;
            cnt         <= RST_LOAD;
            pending     <= '0;
            sel_active  <= '0;
            tile_clk_en <= onehot('0);
            tile_rst_n  <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b1;
            switch_done <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            pending     <= pend_nxt;
            sel_err     <= bus.sel_req_valid && !in_range;
            switch_done <= 1'b0;
            case (state)
                RUN: begin
                    if (req_ok && bus.sel_req != sel_active) begin
                        state      <= DRAIN;
                        cnt        <= RST_LOAD;
                        tile_rst_n <= '0;
                        out_valid  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state       <= GATE;
                        cnt         <= GAP_LOAD;
                        sel_active  <= pend_nxt;
                        tile_clk_en <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GATE: begin
                    if (cnt == '0) begin
                        state       <= WAKE;
                        cnt         <= RST_LOAD;
                        tile_clk_en <= onehot(sel_active);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAKE: begin
                    if (cnt == '0) begin
                        // Woken tile is still in reset, so a redirect skips DRAIN.
                        if (pend_nxt != sel_active) begin
                            state       <= GATE;
                            cnt         <= GAP_LOAD;
                            sel_active  <= pend_nxt;
                            tile_clk_en <= '0;
                        end else begin
                            state       <= RUN;
                            tile_rst_n  <= onehot(sel_active);
                            out_valid   <= 1'b1;
                            busy        <= 1'b0;
                            switch_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= WAKE;
            endcase
        end
    end

    assign bus.sel_active  = sel_active;
    assign bus.tile_clk_en = tile_clk_en;
    assign bus.tile_rst_n  = tile_rst_n;
    assign bus.out_valid   = out_valid;
    assign bus.busy        = busy;
    assign bus.switch_done = switch_done;
    assign bus.sel_err     = sel_err;
endmodule

// File: tb/tb_microtile_switch_sequencer.sv
// tb/tb_microtile_switch_sequencer.sv - scoreboard bench for microtile_switch_sequencer
module tb_microtile_switch_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    microtile_switch_sequencer_if #(.NUM_TILES(4), .SEL_W(2)) bus ();
    microtile_switch_sequencer_if #(.NUM_TILES(3), .SEL_W(2)) bus3 ();

    microtile_switch_sequencer #(.NUM_TILES(4), .SEL_W(2), .RST_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    microtile_switch_sequencer #(.NUM_TILES(3), .SEL_W(2), .RST_CYCLES(4), .GAP_CYCLES(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    localparam int K_RUN = 0, K_DONE = 1, K_DRAIN = 2, K_GATE = 3, K_WAKE = 4;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected output snapshot: {sel_active, clk_en, rst_n, out_valid, busy, switch_done, sel_err}
    function automatic logic [15:0] snap(input logic [1:0] sel, input int kind);
        logic [3:0] oh;
        oh = 4'b0001 << sel;
        case (kind)
            K_RUN:   return {sel, oh,   oh,   1'b1, 1'b0, 1'b0, 1'b0};
            K_DONE:  return {sel, oh,   oh,   1'b1, 1'b0, 1'b1, 1'b0};
            K_DRAIN: return {sel, oh,   4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
            K_GATE:  return {sel, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
            default: return {sel, oh,   4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        endcase
    endfunction

    function automatic logic [15:0] observed();
        return {bus.sel_active, bus.tile_clk_en, bus.tile_rst_n,
                bus.out_valid, bus.busy, bus.switch_done, bus.sel_err};
    endfunction

    task automatic push(input string tag, input logic [1:0] sel, input int kind, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.tag = $sformatf("%s[%0d]", tag, i);
            e.v   = snap(sel, kind);
            sb.push_back(e);
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, 32'(observed()), 32'(e.v));
        end
    endtask

    task automatic strobe(input logic [1:0] s);
        bus.sel_req       = s;
        bus.sel_req_valid = 1'b1;
        cycle();
        bus.sel_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [1:0] prev_sel;
    int         wait_cnt;

    initial begin
        rst = 1'b1;
        bus.sel_req = '0;
        bus.sel_req_valid = 1'b0;
        bus3.sel_req = '0;
        bus3.sel_req_valid = 1'b0;

        push("reset", 2'd0, K_WAKE, 2);
        idle(2);
        rst = 1'b0;
        push("pwr_wake", 2'd0, K_WAKE, 3);
        push("pwr_done", 2'd0, K_DONE, 1);
        push("pwr_run", 2'd0, K_RUN, 1);
        idle(5);

        push("sw02_drain", 2'd0, K_DRAIN, 4);
        push("sw02_gate", 2'd2, K_GATE, 2);
        push("sw02_wake", 2'd2, K_WAKE, 4);
        push("sw02_done", 2'd2, K_DONE, 1);
        push("sw02_run", 2'd2, K_RUN, 1);
        strobe(2'd2);
        idle(11);

        push("rd_drain", 2'd2, K_DRAIN, 4);
        push("rd_gate3", 2'd3, K_GATE, 2);
        push("rd_wake3", 2'd3, K_WAKE, 4);
        push("rd_gate1", 2'd1, K_GATE, 2);
        push("rd_wake1", 2'd1, K_WAKE, 4);
        push("rd_done", 2'd1, K_DONE, 1);
        push("rd_run", 2'd1, K_RUN, 1);
        strobe(2'd0);
        strobe(2'd3);
        idle(3);
        strobe(2'd1);
        idle(12);

        push("same_tile", 2'd1, K_RUN, 3);
        strobe(2'd1);
        idle(2);

        push("mid_drain", 2'd1, K_DRAIN, 4);
        push("mid_gate", 2'd2, K_GATE, 1);
        push("mid_reset", 2'd0, K_WAKE, 1);
        push("mid_wake", 2'd0, K_WAKE, 3);
        push("mid_done", 2'd0, K_DONE, 1);
        push("mid_run", 2'd0, K_RUN, 1);
        strobe(2'd2);
        idle(4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(5);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        bus3.sel_req = 2'd3;
        bus3.sel_req_valid = 1'b1;
        cycle();
        bus3.sel_req_valid = 1'b0;
        check_eq("inv_err", 32'(bus3.sel_err), 32'd1);
        check_eq("inv_busy", 32'(bus3.busy), 32'd0);
        check_eq("inv_sel", 32'(bus3.sel_active), 32'd0);
        cycle();
        check_eq("inv_err_clr", 32'(bus3.sel_err), 32'd0);
        idle(4);
        check_eq("inv_hold_run", 32'({bus3.out_valid, bus3.busy, bus3.sel_active}), 32'({1'b1, 1'b0, 2'd0}));

        prev_sel = bus.sel_active;
        for (int i = 0; i < 10000; i++) begin
            bus.sel_req       = 2'($urandom_range(0, 3));
            bus.sel_req_valid = ($urandom_range(0, 7) == 0);
            cycle();
            check_eq("inv_onehot", 32'($countones(bus.tile_clk_en) <= 1), 32'd1);
            check_eq("inv_rstn", 32'((bus.tile_rst_n == '0) || bus.out_valid), 32'd1);
            if (bus.sel_active != prev_sel)
                check_eq("inv_sel_gated", 32'(bus.tile_clk_en), 32'd0);
            prev_sel = bus.sel_active;
        end
        bus.sel_req_valid = 1'b0;

        wait_cnt = 0;
        while (!bus.out_valid && wait_cnt < 40) begin
            cycle();
            wait_cnt++;
        end
        check_eq("settle_run", 32'(bus.out_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/microtile_switch_sequencer.md
Name: microtile_switch_sequencer

Overview:
- Sequences hand-over of the shared microtile slot between NUM_TILES sub-projects in the group container.
- Replaces the raw combinational select with a glitch-free, reset-bracketed switch.
- The outgoing tile is held in reset with its clock running, then its clock is gated for a guard gap. The incoming tile is then clocked under reset for a fixed period before the output mux is declared valid.
- Sits between the select pins and the per-tile clk/rst_n/ui_in gating plus the uo_out mux.

Parameters:
- NUM_TILES, 4, number of microtiles (2..16).
- SEL_W, 2, width of select, equal to clog2(NUM_TILES).
- RST_CYCLES, 4, cycles of asserted tile reset with the clock enabled (>=1).
- GAP_CYCLES, 2, cycles with all tile clocks gated between tiles (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sel_req  in  SEL_W  requested tile index.
- sel_req_valid  in  1  single-cycle strobe qualifying sel_req.
- sel_active  out  SEL_W  tile currently owning the slot; drives the uo_out mux.
- tile_clk_en  out  NUM_TILES  per-tile clock enable; at most one bit high.
- tile_rst_n  out  NUM_TILES  per-tile active-low reset; 0 for every tile not in RUN.
- out_valid  out  1  high only in RUN; when low, downstream forces uo_out and ui_in to 0.
- busy  out  1  high in any state other than RUN.
- switch_done  out  1  one-cycle pulse on the first RUN cycle after any WAKE.
- sel_err  out  1  one-cycle pulse when a strobed sel_req >= NUM_TILES.

Behaviour:
- All outputs are registered.
- A single down-counter of width clog2(max(RST_CYCLES,GAP_CYCLES)+1) times every state.
- States: RUN, DRAIN, GATE, WAKE.

Reset (rst=1 at an edge):
- state=WAKE, sel_active=0, pending=0, counter=RST_CYCLES-1.
- tile_clk_en=one-hot(0), tile_rst_n=all 0.
- out_valid=0, busy=1, switch_done=0, sel_err=0.
- Reset mid-switch aborts the switch immediately and restarts at tile 0.

Request sampling:
- A request is a strobe with sel_req < NUM_TILES.
- It is latched into the pending register in any state; the latest request wins.
- A strobe with sel_req >= NUM_TILES is dropped. sel_err pulses on the next cycle and pending is unchanged.

RUN:
- tile_clk_en=one-hot(sel_active), tile_rst_n=one-hot(sel_active), out_valid=1, busy=0.
- A valid strobe with sel_req == sel_active is ignored.
- A valid strobe with sel_req != sel_active transitions to DRAIN on the same edge, with counter=RST_CYCLES-1.

DRAIN:
- Clock enable stays on the old tile and its tile_rst_n=0. out_valid=0, busy=1.
- When counter reaches 0: go to GATE, counter=GAP_CYCLES-1, and sel_active<=pending.

GATE:
- tile_clk_en=0, tile_rst_n=0.
- When counter reaches 0: go to WAKE, counter=RST_CYCLES-1.

WAKE:
- tile_clk_en=one-hot(sel_active), tile_rst_n=0.
- When counter reaches 0:
  - if pending != sel_active, go to GATE, counter=GAP_CYCLES-1, sel_active<=pending. The tile is already in reset, so DRAIN is skipped.
  - otherwise go to RUN and pulse switch_done.

Latency and pending rules:
- Strobe accepted in RUN at edge k: the first RUN-state cycle begins at edge k+RST_CYCLES+GAP_CYCLES+RST_CYCLES (edge k+10 with defaults). out_valid and switch_done are high in that cycle.
- A strobe arriving in DRAIN or GATE only updates pending. It is applied at the DRAIN to GATE transition (sel_active<=pending) or at the end of WAKE, and never extends the current DRAIN or GATE.
- A strobe on the same edge that a counter expires is latched first, so the new value is used for that transition.

Invariants:
- tile_clk_en is never multi-hot.
- tile_rst_n has at most one bit high, and only in RUN.

Test Plan:
- Power-up: rst high 2 cycles, then low. Required: tile_clk_en=0001 and tile_rst_n=0000 for 4 cycles, then out_valid=1, tile_rst_n=0001, switch_done pulses once, busy=0.
- Switch 0->2: strobe sel_req=2 in RUN at edge k. Required:
  - DRAIN 4 cycles (clk_en=0001, rst_n=0000).
  - GATE 2 cycles (clk_en=0000, sel_active=2).
  - WAKE 4 cycles (clk_en=0100).
  - RUN at edge k+10, with out_valid=1 and rst_n=0100.
- Redirect: strobe 3 during DRAIN, then strobe 1 during GATE. Required:
  - sel_active=3 at GATE entry.
  - After WAKE(3), a further GATE is entered and sel_active=1.
  - Final RUN has clk_en=0010; switch_done pulses once at the end.
- Same-tile and invalid: in RUN with sel_active=1, strobe 1 -> no state change, busy stays 0. With NUM_TILES=3, strobe 3 -> sel_err one-cycle pulse and pending unchanged.
- Reset mid-operation: assert rst during GATE. Required: the next cycle shows the reset values (sel_active=0, clk_en=0001), and the power-up sequence repeats.
- Random strobes over 10k cycles. Checks:
  - tile_clk_en is never multi-hot.
  - tile_rst_n is high only when out_valid=1.
  - sel_active changes only while tile_clk_en=0.
